dmem_arbiter: RTL and testbench

- Arbitrates the single-port 1024x32 data RAM between two requesters: the pipeline MEM stage (CPU port) and the DMA/debug loader (DMA port).
- Sits between both requesters and the RAM ports we/addr/din/dout.
- CPU has fixed priority. DMA is protected from starvation by a wait counter and may lock the RAM for short bursts.
- Issues at most one RAM access per cycle and returns read data with a registered valid one cycle after grant.

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data RAM between the pipeline MEM stage (CPU port)
//   and the DMA/debug loader (DMA port). At most one RAM access per cycle.
//   CPU has fixed priority. A DMA wait counter forces a DMA win after MAX_WAIT
//   consecutive denied cycles. Once granted, the DMA may hold the RAM for a
//   burst of up to 2**BLW-1 beats. Read data comes straight from ram_dout.
//   A registered rvalid marks it one cycle after the granted read.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (held until cpu_gnt)
//   cpu_gnt                    CPU access issued this cycle (comb)
//   cpu_rvalid, cpu_rdata      CPU read return
//   dma_req/we/addr/wdata      DMA request (held until dma_gnt)
//   dma_burst_len              burst beats, sampled on first grant (0 -> 1)
//   dma_gnt                    DMA access issued this cycle (comb)
//   dma_rvalid, dma_rdata      DMA read return
//   dma_burst_done             final granted beat of a DMA burst
//   ram_we/addr/din, ram_dout  RAM port (RAM writes on negedge, reads on posedge)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int BLW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [BLW-1:0] dma_burst_len,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_burst_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int SW = 4;  // MAX_WAIT is at most 15
    localparam logic [SW-1:0]  MAX_W   = SW'(MAX_WAIT);
    localparam logic [BLW-1:0] BL_ONE  = BLW'(1);

    typedef enum logic {ARB, BURST} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t         state, state_nxt;
    logic [BLW-1:0] remaining, rem_nxt;
    logic [SW-1:0]  starve_cnt;
    req_t           cpu_r, dma_r, ram_r;

    assign cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_r = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        case (state)
            ARB: begin
                // A zero burst length behaves like one, so only >1 opens a burst
                if (dma_gnt && dma_burst_len > BL_ONE) begin
                    state_nxt = BURST;
                    rem_nxt   = dma_burst_len - BL_ONE;
                end
            end
            BURST: begin
                if (!dma_req) begin
                    // Requester dropped out: abandon the rest of the burst
                    state_nxt = ARB;
                    rem_nxt   = '0;
                end else begin
                    rem_nxt = remaining - BL_ONE;
                    if (remaining == BL_ONE) state_nxt = ARB;
                end
            end
            default: begin
                state_nxt = ARB;
                rem_nxt   = '0;
            end
        endcase
    end

    // Output logic: grants, burst-done, RAM mux
    always_comb begin
        cpu_gnt        = 1'b0;
        dma_gnt        = 1'b0;
        dma_burst_done = 1'b0;
        if (!reset) begin
            case (state)
                ARB: begin
                    if (dma_req && starve_cnt == MAX_W) dma_gnt = 1'b1;
                    else if (cpu_req)                   cpu_gnt = 1'b1;
                    else if (dma_req)                   dma_gnt = 1'b1;
                    dma_burst_done = dma_gnt && (dma_burst_len <= BL_ONE);
                end
                BURST: begin
                    dma_gnt        = dma_req;
                    dma_burst_done = dma_req && (remaining == BL_ONE);
                end
                default: ;
            endcase
        end

        ram_r = '0;
        if (cpu_gnt)      ram_r = cpu_r;
        else if (dma_gnt) ram_r = dma_r;
    end

    assign ram_we   = ram_r.we & (cpu_gnt | dma_gnt);
    assign ram_addr = ram_r.addr;
    assign ram_din  = ram_r.wdata;

    // Starvation counter: counts denied DMA cycles, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (dma_gnt)
            starve_cnt <= '0;
        else if (dma_req && starve_cnt != MAX_W)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Read return: RAM output is registered on posedge, so data and valid line up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
        end
    end

    assign cpu_rdata = ram_dout;
    assign dma_rdata = ram_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural 1024x32 RAM
//   (write on negedge, registered read on posedge). Each row of the vector
//   table is one clock cycle: inputs and the expected outputs for that cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [9:0]  cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic [3:0]  dma_burst_len;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_burst_done;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_burst_len(dma_burst_len), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata), .dma_burst_done(dma_burst_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM model
    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(negedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    always @(posedge clk) ram_dout <= mem[ram_addr];

    typedef struct {
        logic        cr, cw; logic [9:0] ca; logic [31:0] cd;
        logic        dr, dw; logic [9:0] da; logic [31:0] dd; logic [3:0] bl;
        logic        cg, dg, done, crv, drv; logic [31:0] rd;
        logic        we; logic [9:0] addr; logic [31:0] din;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic cr, cw, input logic [9:0] ca, input logic [31:0] cd,
        input logic dr, dw, input logic [9:0] da, input logic [31:0] dd, input logic [3:0] bl,
        input logic cg, dg, done, crv, drv, input logic [31:0] rd,
        input logic we, input logic [9:0] addr, input logic [31:0] din);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.bl = bl;
        v.cg = cg; v.dg = dg; v.done = done; v.crv = crv; v.drv = drv; v.rd = rd;
        v.we = we; v.addr = addr; v.din = din;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
        dma_burst_len = v.bl;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " cpu_gnt"}, 32'(cpu_gnt), 0);
        chk({nm, " dma_gnt"}, 32'(dma_gnt), 0);
        chk({nm, " ram_we"}, 32'(ram_we), 0);
        chk({nm, " burst_done"}, 32'(dma_burst_done), 0);
        chk({nm, " cpu_rvalid"}, 32'(cpu_rvalid), 0);
        chk({nm, " dma_rvalid"}, 32'(dma_rvalid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- vector table ----------------
        // DMA single write DEADBEEF @5, then CPU readback
        vt.push_back(mk(0,0,10'h0,0,          1,1,10'h5,32'hDEADBEEF,1, 0,1,1,0,0,0,            1,10'h5,32'hDEADBEEF));
        vt.push_back(mk(1,0,10'h5,0,          0,0,0,0,0,               1,0,0,0,0,0,            0,10'h5,0));
        vt.push_back(mk(0,0,0,0,              0,0,0,0,0,               0,0,0,1,0,32'hDEADBEEF, 0,0,0));
        // Both requesting: 4 CPU grants then 1 DMA, twice
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 4; k++)
                vt.push_back(mk(1,0,10'h5,0, 1,1,10'h20,32'hA5A5,1, 1,0,0,(k != 0 || rep == 0) ? (rep == 0 ? (k != 0) : 1'b0) | (k != 0) : 1'b0,0,32'hDEADBEEF, 0,10'h5,0));
            vt.push_back(mk(1,0,10'h5,0, 1,1,10'h20,32'hA5A5,1, 0,1,1,1,0,32'hDEADBEEF, 1,10'h20,32'hA5A5));
        end
        // Burst of 4 writes 0x100.. to 0x10.. with CPU reading throughout
        vt.push_back(mk(1,0,10'h5,0, 1,1,10'h10,32'h100,4, 1,0,0,0,0,0,            0,10'h5,0));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(1,0,10'h5,0, 1,1,10'h10,32'h100,4, 1,0,0,1,0,32'hDEADBEEF, 0,10'h5,0));
        vt.push_back(mk(1,0,10'h5,0, 1,1,10'h10,32'h100,4, 0,1,0,1,0,32'hDEADBEEF, 1,10'h10,32'h100));
        for (int k = 1; k < 4; k++)
            vt.push_back(mk(1,0,10'h5,0, 1,1,10'(16+k),32'(256+k),4, 0,1,(k == 3),0,0,0, 1,10'(16+k),32'(256+k)));
        vt.push_back(mk(1,0,10'h10,0, 0,0,0,0,0, 1,0,0,0,0,0, 0,10'h10,0));
        for (int k = 1; k < 4; k++)
            vt.push_back(mk(1,0,10'(16+k),0, 0,0,0,0,0, 1,0,0,1,0,32'(256+k-1), 0,10'(16+k),0));
        vt.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,1,0,32'h103, 0,0,0));
        // Burst of 6 aborted after 2 beats
        vt.push_back(mk(0,0,0,0,       1,1,10'h30,32'h300,6, 0,1,0,0,0,0, 1,10'h30,32'h300));
        vt.push_back(mk(1,0,10'h30,0,  1,1,10'h31,32'h301,6, 0,1,0,0,0,0, 1,10'h31,32'h301));
        vt.push_back(mk(1,0,10'h30,0,  0,0,0,0,0,            0,0,0,0,0,0, 0,0,0));
        vt.push_back(mk(1,0,10'h30,0,  0,0,0,0,0,            1,0,0,0,0,0, 0,10'h30,0));
        vt.push_back(mk(1,0,10'h31,0,  0,0,0,0,0,            1,0,0,1,0,32'h300, 0,10'h31,0));
        vt.push_back(mk(0,0,0,0,       0,0,0,0,0,            0,0,0,1,0,32'h301, 0,0,0));
        // CPU write then immediate read of top address
        vt.push_back(mk(1,1,10'h3FF,32'h12345678, 0,0,0,0,0, 1,0,0,0,0,0, 1,10'h3FF,32'h12345678));
        vt.push_back(mk(1,0,10'h3FF,0,            0,0,0,0,0, 1,0,0,0,0,0, 0,10'h3FF,0));
        vt.push_back(mk(0,0,0,0,                  0,0,0,0,0, 0,0,0,1,0,32'h12345678, 0,0,0));
        // DMA read with burst_len 0 behaves as a single beat
        vt.push_back(mk(0,0,0,0, 1,0,10'h20,0,0, 0,1,1,0,0,0,         0,10'h20,0));
        vt.push_back(mk(0,0,0,0, 0,0,0,0,0,      0,0,0,0,1,32'hA5A5,  0,0,0));

        // ---------------- reset state ----------------
        idle();
        reset = 1'b1;
        cpu_req = 1'b1;
        #3;
        chk_quiet("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle();
        #3;
        chk_quiet("post-reset");

        // ---------------- table ----------------
        foreach (vt[i]) begin
            @(posedge clk);
            #1 drive(vt[i]);
            #3;
            chk($sformatf("v%0d cpu_gnt", i),    32'(cpu_gnt),        32'(vt[i].cg));
            chk($sformatf("v%0d dma_gnt", i),    32'(dma_gnt),        32'(vt[i].dg));
            chk($sformatf("v%0d burst_done", i), 32'(dma_burst_done), 32'(vt[i].done));
            chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid),     32'(vt[i].crv));
            chk($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid),     32'(vt[i].drv));
            chk($sformatf("v%0d ram_we", i),     32'(ram_we),         32'(vt[i].we));
            chk($sformatf("v%0d ram_addr", i),   32'(ram_addr),       32'(vt[i].addr));
            chk($sformatf("v%0d ram_din", i),    ram_din,             vt[i].din);
            if (vt[i].crv) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].rd);
            if (vt[i].drv) chk($sformatf("v%0d dma_rdata", i), dma_rdata, vt[i].rd);
        end

        // ---------------- reset mid-burst with a read outstanding ----------------
        @(posedge clk);
        #1 drive(mk(0,0,0,0, 1,0,10'h10,0,4, 0,0,0,0,0,0, 0,0,0));
        #3 chk("mb beat1 dma_gnt", 32'(dma_gnt), 1);
        @(posedge clk);
        #1 dma_addr = 10'h11;
        #3 chk("mb beat2 dma_gnt", 32'(dma_gnt), 1);
        chk("mb beat2 dma_rvalid", 32'(dma_rvalid), 1);
        @(posedge clk);
        #1 dma_addr = 10'h12;
        #1 reset = 1'b1;
        #1 chk_quiet("mb in reset");
        // Both requesting, single beats, while reset still held
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h5;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h20; dma_burst_len = 4'd1;
        @(posedge clk);
        #1 chk_quiet("mb held");
        reset = 1'b0;
        #3;
        chk("mb rel cpu_gnt", 32'(cpu_gnt), 1);
        chk("mb rel dma_gnt", 32'(dma_gnt), 0);
        chk("mb rel dma_rvalid", 32'(dma_rvalid), 0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #4;
            chk($sformatf("mb arb%0d cpu_gnt", k), 32'(cpu_gnt), 1);
            chk($sformatf("mb arb%0d dma_gnt", k), 32'(dma_gnt), 0);
        end
        @(posedge clk);
        #4;
        chk("mb arb4 dma_gnt", 32'(dma_gnt), 1);
        chk("mb arb4 cpu_gnt", 32'(cpu_gnt), 0);
        chk("mb arb4 burst_done", 32'(dma_burst_done), 1);

        @(posedge clk);
        #1 idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
